// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial add/subtract unit: FSM state encodings,
// the default operand width and the bit-counter sizing helper.
package serial_addsub_pkg;

    localparam int unsigned DefaultWidth = 4;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSum  = 2'd1;
    localparam logic [1:0] StNeg  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Bits needed to count 0..w-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_addsub_cell.sv
// One-bit XOR-invert full adder. i_s inverts B so the same cell performs the
// add and the two's-complement subtract step.
module full_addsub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_s,
    output logic o_s,
    output logic o_c
);

    logic b_eff;

    // Sum and carry of a + (b ^ s) + c.
    always_comb begin
        b_eff = i_b ^ i_s;
        o_s   = i_a ^ b_eff ^ i_c;
        o_c   = ((i_a ^ b_eff) & i_c) | (i_a & b_eff);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock, with valid/ready on
// both sides. Build option SERIAL_ADDSUB_SIGNMAG_EN adds a NEG pass that turns a
// negative difference into its magnitude; without it o_s is the raw
// two's-complement difference.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_neg
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             neg_q, neg_d;

    logic cell_a, cell_b, cell_s, cell_sum, cell_cout;

    // Steer the single adder cell: operand bits in SUM, ~r0 + carry in NEG.
    always_comb begin
`ifdef SERIAL_ADDSUB_SIGNMAG_EN
        if (state_q == StNeg) begin
            cell_a = ~r_q[0];
            cell_b = 1'b0;
            cell_s = 1'b0;
        end else begin
            cell_a = a_q[0];
            cell_b = b_q[0];
            cell_s = sub_q;
        end
`else
        cell_a = a_q[0];
        cell_b = b_q[0];
        cell_s = sub_q;
`endif
    end

    full_addsub_cell u_cell (
        .i_a (cell_a),
        .i_b (cell_b),
        .i_c (carry_q),
        .i_s (cell_s),
        .o_s (cell_sum),
        .o_c (cell_cout)
    );

    // FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        neg_d   = neg_q;

        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    sub_d   = i_sub;
                    carry_d = i_sub;  // the +1 of two's complement
                    cnt_d   = '0;
                    state_d = StSum;
                end
            end
            StSum: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = {cell_sum, r_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    c_d   = cell_cout;
                    neg_d = sub_q & ~cell_cout;
                    cnt_d = '0;
`ifdef SERIAL_ADDSUB_SIGNMAG_EN
                    if (sub_q & ~cell_cout) begin
                        carry_d = 1'b1;
                        state_d = StNeg;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef SERIAL_ADDSUB_SIGNMAG_EN
            StNeg: begin
                r_d     = {cell_sum, r_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
`else
            StNeg: state_d = StIdle;  // unreachable without the NEG pass
`endif
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            neg_q   <= neg_d;
        end
    end

    // Handshake flags decode the state; result fields come straight from registers.
    always_comb begin
        o_ready = (state_q == StIdle);
        o_valid = (state_q == StDone);
        o_s     = r_q;
        o_c     = c_q;
        o_neg   = neg_q;
    end

endmodule
